pc_stack_unit: RTL
==================

// Module: pc_stack_unit
// PURPOSE
//  Parametrised program counter with absolute/relative jumps, a hardware
//  call/return stack, stall and halt. Sits at the head of the fetch path and
//  drives the instruction-memory address each cycle. Supersedes the plain
//  increment/absolute-jump PC: adds branch offsets, subroutine calls and error flags.
// PARAMETERS
//  D           12  PC / address width in bits
//  STACK_DEPTH 4   return-address stack entries (>=1)
//  START_ADDR  0   prog_ctr value loaded on reset
//  PROG_LEN    2**D  program length in words; used only when PC_BOUNDS_EN is defined
// PORTS
//  clk            in   1              system clock; all state on rising edge
//  reset          in   1              synchronous, active-high reset
//  stall          in   1              hold prog_ctr this cycle
//  absjump_en     in   1              next pc = target
//  reljump_en     in   1              next pc = prog_ctr + offset
//  target         in   D              absolute jump / call destination
//  offset         in   D              signed two's-complement relative offset
//  call_en        in   1              push prog_ctr+1, next pc = target
//  ret_en         in   1              pop stack top into pc
//  halt_in        in   1              request halt (sticky)
//  prog_ctr       out  D              current program counter
//  halted         out  1              pc frozen until reset
//  stack_empty    out  1              no return addresses stored
//  stack_full     out  1              STACK_DEPTH entries stored
//  overflow_err   out  1              sticky: call attempted while full
//  underflow_err  out  1              sticky: ret attempted while empty
// BEHAVIOUR
//  - Reset (sync, active-high): prog_ctr=START_ADDR, stack count=0, stack_empty=1,
//    stack_full=0, halted=0, overflow_err=0, underflow_err=0, started flag=0.
//    Reset asserted mid-operation wins over every other input that cycle.
//  - Start flag: first clk edge after reset release only sets started; prog_ctr
//    holds START_ADDR. Updates begin on the following edge.
//  - Once started, per-edge priority (highest first):
//    halted/halt_in > stall > ret_en > call_en > absjump_en > reljump_en > +1.
//  - halt_in=1: halted<=1, prog_ctr holds; stays until reset.
//  - stall=1: prog_ctr and stack unchanged; control inputs ignored.
//  - ret_en, stack non-empty: prog_ctr<=top, count-1. Empty: underflow_err<=1,
//    prog_ctr<=prog_ctr+1, count unchanged.
//  - call_en, stack not full: push prog_ctr+1 (mod 2^D), prog_ctr<=target,
//    count+1. Full: overflow_err<=1, no push, no jump, prog_ctr<=prog_ctr+1.
//  - absjump_en: prog_ctr<=target. reljump_en: prog_ctr<=prog_ctr+offset, D-bit
//    add, carry discarded (wraps mod 2^D). Default: prog_ctr<=prog_ctr+1, wraps
//    2^D-1 -> 0.
//  - Stack is LIFO, count 0..STACK_DEPTH; stack_empty/stack_full registered,
//    reflect count after the edge. One push or pop max per cycle.
//  - Error flags are sticky until reset; they do not halt the PC.
//  - Latency: all outputs registered; control seen at edge N is visible after N.
// CONFIGURATION
//  PC_BOUNDS_EN defined: any computed next pc >= PROG_LEN (incl. jump/ret targets)
//    sets halted<=1 and prog_ctr holds its current value instead of updating.
//  PC_BOUNDS_EN undefined: no bounds check, PROG_LEN ignored, pc wraps mod 2^D.
// TESTING
//  1 reset 1 cycle, all controls 0 -> prog_ctr 000 for 2 edges, then 001,002,003.
//  2 at pc=010 call_en, target=100; at 102 ret_en -> pc 100,101,102,011; stack_empty=1.
//  3 STACK_DEPTH=4: 5 calls without ret -> stack_full=1 after 4th, overflow_err=1
//    after 5th, pc=last target+1; 5 rets -> 4 pops then underflow_err=1.
//  4 pc=020 reljump offset=FFE -> 01E; pc=FFF default -> 000 (no bounds macro);
//    with PC_BOUNDS_EN, PROG_LEN=256, pc=0FF -> halted=1, pc stays 0FF.
//  5 stall=1 with absjump_en,target=300 -> pc unchanged; halt_in then reset
//    mid-run -> halted=1 pc frozen, then pc=START_ADDR, all flags 0.
//  6 call_en+ret_en+absjump_en same cycle, stack non-empty -> ret wins, no push.

Source files
------------

// File: rtl/pc_stack_if.sv
// pc_stack_if: control and status bundle between the fetch sequencer and
// pc_stack_unit.
//   master : drives stall/halt/jump/call/ret controls, receives PC and flags
//   slave  : the PC unit; receives controls, drives prog_ctr and status flags
// D is the PC/address width and must match the unit's D.
interface pc_stack_if #(parameter int D = 12);
    logic         stall;
    logic         absjump_en;
    logic         reljump_en;
    logic [D-1:0] target;
    logic [D-1:0] offset;
    logic         call_en;
    logic         ret_en;
    logic         halt_in;
    logic [D-1:0] prog_ctr;
    logic         halted;
    logic         stack_empty;
    logic         stack_full;
    logic         overflow_err;
    logic         underflow_err;

    modport master (
        output stall, absjump_en, reljump_en, target, offset, call_en, ret_en, halt_in,
        input  prog_ctr, halted, stack_empty, stack_full, overflow_err, underflow_err
    );

    modport slave (
        input  stall, absjump_en, reljump_en, target, offset, call_en, ret_en, halt_in,
        output prog_ctr, halted, stack_empty, stack_full, overflow_err, underflow_err
    );
endinterface

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with absolute/relative jumps, a LIFO
// return-address stack for call/ret, stall, sticky halt and sticky
// overflow/underflow error flags. Drives the instruction-memory address.
//
// Ports:
//   clk    system clock, all state on the rising edge
//   reset  synchronous active-high reset
//   bus    pc_stack_if.slave: controls in (stall, absjump_en, reljump_en,
//          target, offset, call_en, ret_en, halt_in), registered status out
//          (prog_ctr, halted, stack_empty, stack_full, overflow_err,
//          underflow_err)
//
// Parameters: D (PC width), STACK_DEPTH (>=1), START_ADDR (reset PC),
//             PROG_LEN (program length, only used with PC_BOUNDS_EN).
//
// Optional feature: define PC_BOUNDS_EN to halt (PC holding its value) when
// any computed next PC is >= PROG_LEN. Without it the PC wraps mod 2^D.
module pc_stack_unit #(
    parameter int D           = 12,
    parameter int STACK_DEPTH = 4,
    parameter int START_ADDR  = 0,
    parameter int PROG_LEN    = 2**D
) (
    input  logic        clk,
    input  logic        reset,
    pc_stack_if.slave   bus
);
    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [D:0] PLEN = (D+1)'(PROG_LEN);

    logic [D-1:0]  prog_ctr;
    logic [CW-1:0] count;
    logic          started;
    logic          halted;
    logic          stack_empty;
    logic          stack_full;
    logic          overflow_err;
    logic          underflow_err;
    logic [D-1:0]  stk [STACK_DEPTH];

    logic [D-1:0]  pc_inc;
    logic [D-1:0]  nxt_pc;
    logic [AW-1:0] top_idx;
    logic          do_push;
    logic          do_pop;
    logic          set_ovf;
    logic          set_unf;
    logic          out_of_range;
    logic          advance;

    assign pc_inc  = prog_ctr + 1'b1;
    assign top_idx = AW'(count - 1'b1);

    // Next-PC selection for a normal (started, not halted, not stalled) edge.
    // ret beats call beats absolute beats relative beats increment.
    always_comb begin
        nxt_pc  = pc_inc;
        do_push = 1'b0;
        do_pop  = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (bus.ret_en) begin
            if (!stack_empty) begin
                nxt_pc = stk[top_idx];
                do_pop = 1'b1;
            end else begin
                set_unf = 1'b1;
            end
        end else if (bus.call_en) begin
            if (!stack_full) begin
                nxt_pc  = bus.target;
                do_push = 1'b1;
            end else begin
                set_ovf = 1'b1;
            end
        end else if (bus.absjump_en) begin
            nxt_pc = bus.target;
        end else if (bus.reljump_en) begin
            nxt_pc = prog_ctr + bus.offset;   // D-bit add, carry dropped
        end
    end

`ifdef PC_BOUNDS_EN
    assign out_of_range = ({1'b0, nxt_pc} >= PLEN);
`else
    logic unused_plen;
    assign unused_plen  = ^PLEN;
    assign out_of_range = 1'b0;
`endif

    // True on an edge where the PC/stack actually move.
    assign advance = !reset && started && !halted && !bus.halt_in && !bus.stall && !out_of_range;

    always_ff @(posedge clk) begin
        if (reset) begin
            prog_ctr      <= D'(START_ADDR);
            count         <= '0;
            started       <= 1'b0;
            halted        <= 1'b0;
            stack_empty   <= 1'b1;
            stack_full    <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else if (!started) begin
            started <= 1'b1;            // first edge after release only arms the PC
        end else if (!halted) begin
            if (bus.halt_in) begin
                halted <= 1'b1;
            end else if (!bus.stall) begin
                if (set_ovf) overflow_err  <= 1'b1;
                if (set_unf) underflow_err <= 1'b1;
                if (out_of_range) begin
                    halted <= 1'b1;     // bounds trip: PC and stack hold
                end else begin
                    prog_ctr <= nxt_pc;
                    if (do_push) begin
                        count       <= count + 1'b1;
                        stack_empty <= 1'b0;
                        stack_full  <= (count == CW'(STACK_DEPTH - 1));
                    end
                    if (do_pop) begin
                        count       <= count - 1'b1;
                        stack_full  <= 1'b0;
                        stack_empty <= (count == CW'(1));
                    end
                end
            end
        end
    end

    // Stack storage needs no reset; count alone defines validity.
    always_ff @(posedge clk) begin
        if (advance && do_push) stk[AW'(count)] <= pc_inc;
    end

    assign bus.prog_ctr      = prog_ctr;
    assign bus.halted        = halted;
    assign bus.stack_empty   = stack_empty;
    assign bus.stack_full    = stack_full;
    assign bus.overflow_err  = overflow_err;
    assign bus.underflow_err = underflow_err;
endmodule
